poly_weight_scan_ctrl: RTL

- Sequencer for one decapsulation pass over a stored polynomial of P coefficients.
- Streams every coefficient out of the coefficient RAM, one per cycle, through a 1-cycle-latency read port.
- Writes a 1-bit nonzero mask per coefficient into the mask RAM, counts the nonzeros, and reports whether the Hamming weight equals 2T.
- Sits between the decap top-level control and the lift/weight-check datapath; uses the same start/busy/done handshake style as the other decap sub-blocks.

---
 rtl/poly_weight_scan_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/poly_weight_scan_ctrl.sv
// Streams P coefficients from RAM, writes a per-coefficient nonzero mask, and checks weight == 2*T.
// done pulses P+3 cycles after start is sampled; `define OVERWEIGHT_EXIT_EN enables early exit at 2*T+1 nonzeros.
module poly_weight_scan_ctrl #(
    parameter int P  = 677,
    parameter int T  = 101,
    parameter int AW = 10,
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [CW-1:0] mem_rdata,
    output logic          mask_wen,
    output logic [AW-1:0] mask_waddr,
    output logic          mask_wdata,
    output logic [AW-1:0] nz_count,
    output logic          weight_ok
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST   = AW'(P - 1);
    localparam logic [AW-1:0] TARGET = AW'(2 * T);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          mem_ren_q, mem_ren_d;
    logic [AW-1:0] mem_raddr_q, mem_raddr_d;
    logic          v_q, v_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] nz_q, nz_d;
    logic          weight_ok_q, weight_ok_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rdata_nz;
    logic          hit;

    assign rdata_nz = |mem_rdata;
    assign hit      = v_q & rdata_nz;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mem_ren_d   = 1'b0;
        mem_raddr_d = '0;
        v_d         = mem_ren_q;
        a_d         = mem_raddr_q;
        nz_d        = hit ? nz_q + AW'(1) : nz_q;
        weight_ok_d = weight_ok_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SCAN;
                    mem_ren_d   = 1'b1;
                    mem_raddr_d = '0;
                    addr_d      = AW'(1);
                    nz_d        = '0;
                    weight_ok_d = 1'b0;
                end
            end
            S_SCAN: begin
                // mem_raddr_q is the address issued this cycle; leave once the last one is out
                if (mem_raddr_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    mem_ren_d   = 1'b1;
                    mem_raddr_d = addr_q;
                    addr_d      = addr_q + AW'(1);
                end
            end
            S_DRAIN: state_d = S_CHECK;
            S_CHECK: begin
                weight_ok_d = (nz_q == TARGET);
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef OVERWEIGHT_EXIT_EN
        // Weight already exceeded: drop the in-flight read and jump to the verdict
        if (hit && (nz_q == TARGET)) begin
            nz_d        = AW'(2 * T + 1);
            state_d     = S_CHECK;
            mem_ren_d   = 1'b0;
            mem_raddr_d = '0;
            v_d         = 1'b0;
            a_d         = '0;
        end
`else
`endif

        busy_d = (state_d == S_SCAN) || (state_d == S_DRAIN) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= '0;
            v_q         <= 1'b0;
            a_q         <= '0;
            nz_q        <= '0;
            weight_ok_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_ren_q   <= mem_ren_d;
            mem_raddr_q <= mem_raddr_d;
            v_q         <= v_d;
            a_q         <= a_d;
            nz_q        <= nz_d;
            weight_ok_q <= weight_ok_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_ren    = mem_ren_q;
    assign mem_raddr  = mem_raddr_q;
    assign mask_wen   = v_q;
    assign mask_waddr = v_q ? a_q : '0;
    assign mask_wdata = hit;
    assign nz_count   = nz_q;
    assign weight_ok  = weight_ok_q;

endmodule
